// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
//
// Multi-key debouncer and edge-pulse generator. A slow sampling strobe is
// taken from the rising edge of one bit of the shared free-running divider
// count. Raw keys pass through a two-flop synchronizer. A key's new level is
// accepted only after it has been seen on STABLE_CNT consecutive strobes.
// Each acceptance raises a one-clock press or release pulse.
//
// Parameters:
//   N_KEYS     number of independent key channels
//   TAP        divider bit used as the sampling strobe (0..31)
//   STABLE_CNT consecutive strobes a changed level must persist (>= 1)
//
// Ports:
//   clk          system clock, shared with the divider
//   rst          synchronous, active-high reset
//   clkdiv       free-running divider count
//   key_in       raw asynchronous key levels (1 = pressed by default)
//   key_state    registered debounced level per key
//   key_press    one-clk pulse when key_state goes 0->1
//   key_release  one-clk pulse when key_state goes 1->0
//
// Optional feature (compile-time macro KEY_ACTIVE_LOW_EN):
//   When defined, key_in is inverted ahead of the synchronizer, so a board
//   level of 0 means pressed. Internally 0 still means released.
// -----------------------------------------------------------------------------
module key_debounce #(
  parameter int N_KEYS     = 4,
  parameter int TAP        = 17,
  parameter int STABLE_CNT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       clkdiv,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release
);

  localparam int            CW       = $clog2(STABLE_CNT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

  typedef enum logic {
    ST_STABLE,
    ST_PENDING
  } state_e;

  logic              tap_q, tap_d;
  logic              tick;
  logic [N_KEYS-1:0] key_raw;
  logic [N_KEYS-1:0] sync1_q, sync1_d;
  logic [N_KEYS-1:0] sync2_q, sync2_d;
  logic [N_KEYS-1:0] key_state_q, key_state_d;
  logic [N_KEYS-1:0] key_press_q, key_press_d;
  logic [N_KEYS-1:0] key_release_q, key_release_d;
  state_e            state_q [N_KEYS];
  state_e            state_d [N_KEYS];
  logic [CW-1:0]     cnt_q   [N_KEYS];
  logic [CW-1:0]     cnt_d   [N_KEYS];

  // Only one divider bit is used; the rest are folded into a dummy signal.
  logic clkdiv_unused;
  assign clkdiv_unused = ^clkdiv;

`ifdef KEY_ACTIVE_LOW_EN
  assign key_raw = ~key_in;
`else
  assign key_raw = key_in;
`endif

  // Strobe on the 0->1 edge of the tap bit.
  assign tap_d   = clkdiv[TAP];
  assign tick    = clkdiv[TAP] & ~tap_q;
  assign sync1_d = key_raw;
  assign sync2_d = sync1_q;

  // NOTE: every output of a combinational block gets a default before any
  // branch; a path that leaves one unassigned would infer a latch.
  always_comb begin
    key_state_d   = key_state_q;
    key_press_d   = '0;
    key_release_d = '0;
    for (int k = 0; k < N_KEYS; k++) begin
      state_d[k] = state_q[k];
      cnt_d[k]   = cnt_q[k];
      if (tick) begin
        if (sync2_q[k] != key_state_q[k]) begin
          // In ST_STABLE cnt is zero, so a single-strobe setting accepts at once.
          case (state_q[k])
            ST_STABLE, ST_PENDING: begin
              if (cnt_q[k] == CNT_LAST) begin
                key_state_d[k]   = ~key_state_q[k];
                key_press_d[k]   = ~key_state_q[k];
                key_release_d[k] = key_state_q[k];
                cnt_d[k]         = '0;
                state_d[k]       = ST_STABLE;
              end else begin
                cnt_d[k]   = cnt_q[k] + CW'(1);
                state_d[k] = ST_PENDING;
              end
            end
            default: begin
              cnt_d[k]   = '0;
              state_d[k] = ST_STABLE;
            end
          endcase
        end else begin
          // Level matches again: any partial run is a glitch and is dropped.
          cnt_d[k]   = '0;
          state_d[k] = ST_STABLE;
        end
      end
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      // tap_q starts high so a tap bit already at 1 does not fake an edge.
      tap_q         <= 1'b1;
      sync1_q       <= '0;
      sync2_q       <= '0;
      key_state_q   <= '0;
      key_press_q   <= '0;
      key_release_q <= '0;
      // NOTE: the per-key counter arrays are tiny flop banks, not RAM, so
      // they are reset with everything else to discard pending progress.
      for (int k = 0; k < N_KEYS; k++) begin
        state_q[k] <= ST_STABLE;
        cnt_q[k]   <= '0;
      end
    end else begin
      tap_q         <= tap_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      key_state_q   <= key_state_d;
      key_press_q   <= key_press_d;
      key_release_q <= key_release_d;
      for (int k = 0; k < N_KEYS; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
    end
  end

  assign key_state   = key_state_q;
  assign key_press   = key_press_q;
  assign key_release = key_release_q;

endmodule

// File: tb/tb_key_debounce.sv
// -----------------------------------------------------------------------------
// tb_key_debounce
//
// Scoreboard bench for key_debounce with TAP=2, STABLE_CNT=4, N_KEYS=4 and a
// real counter on clkdiv. The stimulus process drives one clock at a time,
// advances a behavioural model (run-length of differing strobe samples per
// key) and queues the outputs expected after that edge. A separate monitor
// pops one entry per clock on the falling edge and compares.
// Honours KEY_ACTIVE_LOW_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_key_debounce;

  localparam int NK  = 4;
  localparam int TAP = 2;
  localparam int SC  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   clkdiv;
  logic [NK-1:0] key_in;
  logic [NK-1:0] key_state;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;

  key_debounce #(
    .N_KEYS    (NK),
    .TAP       (TAP),
    .STABLE_CNT(SC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clkdiv     (clkdiv),
    .key_in     (key_in),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_release(key_release)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NK-1:0] st;
    logic [NK-1:0] pr;
    logic [NK-1:0] rl;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  // Observed pulse counts, used for phase-level checks.
  int   press_cnt [NK];
  int   rel_cnt   [NK];
  bit   saw_1010;

  // Behavioural model state.
  logic [31:0]   div_cnt;
  logic          m_tap;
  logic [NK-1:0] m_hist1, m_hist2;   // raw input one and two clocks ago
  logic [NK-1:0] m_state;
  int            m_run [NK];         // consecutive strobes seen differing

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [NK-1:0] to_raw(input logic [NK-1:0] pressed);
`ifdef KEY_ACTIVE_LOW_EN
    return ~pressed;
`else
    return pressed;
`endif
  endfunction

  function automatic logic [NK-1:0] to_pressed(input logic [NK-1:0] raw);
`ifdef KEY_ACTIVE_LOW_EN
    return ~raw;
`else
    return raw;
`endif
  endfunction

  // Drive one clock of inputs, predict the outputs after the edge, queue them.
  task automatic step(input logic r, input logic [NK-1:0] raw);
    exp_t          e;
    logic          tick;
    logic [NK-1:0] pr, rl;
    rst     = r;
    key_in  = raw;
    clkdiv  = div_cnt;
    div_cnt = div_cnt + 1;
    pr = '0;
    rl = '0;
    if (r) begin
      m_tap   = 1'b1;
      m_hist1 = '0;
      m_hist2 = '0;
      m_state = '0;
      for (int k = 0; k < NK; k++) m_run[k] = 0;
    end else begin
      tick  = clkdiv[TAP] && !m_tap;
      m_tap = clkdiv[TAP];
      if (tick) begin
        for (int k = 0; k < NK; k++) begin
          if (m_hist2[k] != m_state[k]) begin
            m_run[k]++;
            if (m_run[k] == SC) begin
              m_run[k]   = 0;
              m_state[k] = ~m_state[k];
              if (m_state[k]) pr[k] = 1'b1;
              else            rl[k] = 1'b1;
            end
          end else begin
            m_run[k] = 0;
          end
        end
      end
      m_hist2 = m_hist1;
      m_hist1 = to_pressed(raw);
    end
    e.st = m_state;
    e.pr = pr;
    e.rl = rl;
    @(posedge clk);
    #1;
    sb_q.push_back(e);
  endtask

  task automatic hold(input int n, input logic r, input logic [NK-1:0] raw);
    repeat (n) step(r, raw);
  endtask

  task automatic clear_counts();
    for (int k = 0; k < NK; k++) begin
      press_cnt[k] = 0;
      rel_cnt[k]   = 0;
    end
    saw_1010 = 1'b0;
  endtask

  // Monitor: one expected entry per clock, compared on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("key_state", 32'(key_state), 32'(e.st));
        check("key_press", 32'(key_press), 32'(e.pr));
        check("key_release", 32'(key_release), 32'(e.rl));
        if ((key_press & key_release) != '0)
          check("press_release_excl", 32'(key_press & key_release), 32'd0);
        for (int k = 0; k < NK; k++) begin
          if (key_press[k])   press_cnt[k]++;
          if (key_release[k]) rel_cnt[k]++;
        end
        if (key_press == 4'b1010) saw_1010 = 1'b1;
      end
    end
  end

  initial begin
    logic [NK-1:0] cur;
    clear_counts();
    for (int k = 0; k < NK; k++) m_run[k] = 0;
    m_tap   = 1'b1;
    m_hist1 = '0;
    m_hist2 = '0;
    m_state = '0;
    // Reset with clkdiv 4,5,6; first free cycle sees clkdiv[2]=1 but no strobe.
    div_cnt = 32'd4;
    hold(3, 1'b1, 4'b1111);
    hold(40, 1'b0, to_raw(4'b0000));

    // Press accept on key 0.
    clear_counts();
    hold(60, 1'b0, to_raw(4'b0001));
    check("press0_count", 32'(press_cnt[0]), 32'd1);
    check("press_other_count", 32'(press_cnt[1] + press_cnt[2] + press_cnt[3]), 32'd0);

    // Glitch: sync2 high for exactly 24 clocks = 3 strobes, then a real press.
    clear_counts();
    hold(24, 1'b0, to_raw(4'b0011));
    hold(40, 1'b0, to_raw(4'b0001));
    check("glitch1_count", 32'(press_cnt[1]), 32'd0);
    hold(40, 1'b0, to_raw(4'b0011));
    check("press1_after_glitch", 32'(press_cnt[1]), 32'd1);

    // Release keys 0 and 1.
    clear_counts();
    hold(50, 1'b0, to_raw(4'b0000));
    check("release0_count", 32'(rel_cnt[0]), 32'd1);
    check("release1_count", 32'(rel_cnt[1]), 32'd1);
    check("release0_no_press", 32'(press_cnt[0]), 32'd0);

    // Mid-operation reset: two strobes of progress, reset, then a fresh count.
    clear_counts();
    hold(18, 1'b0, to_raw(4'b0100));
    hold(2, 1'b1, to_raw(4'b0100));
    hold(26, 1'b0, to_raw(4'b0100));
    check("midrst_not_early", 32'(press_cnt[2]), 32'd0);
    hold(24, 1'b0, to_raw(4'b0100));
    check("midrst_press2", 32'(press_cnt[2]), 32'd1);

    // Concurrency: two keys changing in the same clock pulse together.
    hold(60, 1'b0, to_raw(4'b0000));
    clear_counts();
    hold(60, 1'b0, to_raw(4'b1010));
    check("concurrent_1010", 32'(saw_1010), 32'd1);
    check("concurrent_counts", 32'(press_cnt[1] + press_cnt[3]), 32'd2);

    // Random traffic: slow key toggles (long and short holds) and rare resets.
    cur = 4'b1010;
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < NK; k++)
        if ($urandom_range(0, 39) == 0) cur[k] = ~cur[k];
      step(($urandom_range(0, 599) == 0), to_raw(cur));
    end
    hold(2, 1'b0, to_raw(cur));

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
